// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_pkg
// Brief   : Shared op codes, default width and state encoding for the
//           multi-cycle multiply/divide unit.
// Revision: 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // True for the four ops that run through the iterative engine.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_DIV)  || (op == OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_core
// Brief   : Iterative engine: shift-add multiply and restoring divide, one
//           bit per cycle, with sign fix-up folded into the final iteration.
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,        // accepted mult/div, only while idle
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,            // rs / dividend
  input  logic [WIDTH-1:0] b_i,            // rt / divisor
  output logic             busy_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic             result_valid_o  // high during the last iteration cycle
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // Mult: {partial product, remaining multiplier}. Div: {remainder, quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;     // multiplicand or divisor magnitude
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;     // product / quotient sign
  logic                 rneg_q, rneg_d;   // remainder sign
  logic                 dz_q, dz_d;       // divide by zero
  logic [WIDTH-1:0]     raw_a_q, raw_a_d; // raw dividend for the /0 result

  logic                 sgn_op;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_rsh;
  logic [WIDTH:0]       div_diff;
  logic [WIDTH-1:0]     div_qsh;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   iter_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Operand magnitudes and signs at the accept edge.
  always_comb begin
    sgn_op = (op_i == OP_MULT) || (op_i == OP_DIV);
    a_neg  = sgn_op && a_i[WIDTH-1];
    b_neg  = sgn_op && b_i[WIDTH-1];
    a_mag  = a_neg ? ((~a_i) + WIDTH'(1)) : a_i;
    b_mag  = b_neg ? ((~b_i) + WIDTH'(1)) : b_i;
  end

  // One iteration of each datapath; result selection and sign fix-up.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    div_rsh  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_rsh - {1'b0, opb_q};
    div_qsh  = {acc_q[WIDTH-2:0], 1'b0};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], div_qsh | WIDTH'(1)};
    end else begin
      div_next = {div_rsh[WIDTH-1:0], div_qsh};
    end

    iter_next = is_div_q ? div_next : mul_next;

    prod_fix = neg_q  ? ((~iter_next) + (2*WIDTH)'(1)) : iter_next;
    quo_fix  = neg_q  ? ((~iter_next[WIDTH-1:0]) + WIDTH'(1)) : iter_next[WIDTH-1:0];
    rem_fix  = rneg_q ? ((~iter_next[2*WIDTH-1:WIDTH]) + WIDTH'(1))
                      : iter_next[2*WIDTH-1:WIDTH];

    if (!is_div_q) begin
      result_hi_o = prod_fix[2*WIDTH-1:WIDTH];
      result_lo_o = prod_fix[WIDTH-1:0];
    end else if (dz_q) begin
      result_hi_o = raw_a_q;
      result_lo_o = '1;
    end else begin
      result_hi_o = rem_fix;
      result_lo_o = quo_fix;
    end

    result_valid_o = (state_q == RUN) && (cnt_q == LAST);
    busy_o         = (state_q == RUN);
  end

  // Next-state: latch operands on accept, iterate while running.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    raw_a_d  = raw_a_q;
    if (state_q == IDLE) begin
      if (start_i) begin
        state_d  = RUN;
        cnt_d    = '0;
        is_div_d = (op_i == OP_DIV) || (op_i == OP_DIVU);
        neg_d    = a_neg ^ b_neg;
        rneg_d   = a_neg;
        dz_d     = (b_i == '0);
        raw_a_d  = a_i;
        if ((op_i == OP_DIV) || (op_i == OP_DIVU)) begin
          acc_d = {{WIDTH{1'b0}}, a_mag};
          opb_d = b_mag;
        end else begin
          acc_d = {{WIDTH{1'b0}}, b_mag};
          opb_d = a_mag;
        end
      end
    end else begin
      acc_d = iter_next;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        state_d = IDLE;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      raw_a_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      raw_a_q  <= raw_a_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_hilo.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_hilo
// Brief   : HI/LO register owner: accepts mult/div/mthi/mtlo requests,
//           drives the iterative engine and pulses done after each result.
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             accept;
  logic             core_start;
  logic             core_busy;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_valid;

  muldiv_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk           (clk),
    .reset         (reset),
    .start_i       (core_start),
    .op_i          (op),
    .a_i           (in1),
    .b_i           (in2),
    .busy_o        (core_busy),
    .result_hi_o   (res_hi),
    .result_lo_o   (res_lo),
    .result_valid_o(res_valid)
  );

  // Accept logic; reserved op 111 behaves as NOP, and requests while busy are dropped.
  always_comb begin
    accept     = start && !core_busy && (op != OP_NOP) && (op != OP_RSVD);
    core_start = accept && is_muldiv(op);
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = res_valid;
    if (res_valid) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else if (accept && (op == OP_MTHI)) begin
      hi_d = in1;
    end else if (accept && (op == OP_MTLO)) begin
      lo_d = in1;
    end
  end

  // HI/LO architectural registers and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  assign busy = core_busy;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_hilo.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_hilo
// Brief   : Directed self-checking bench for muldiv_hilo with an expected
//           {HI,LO} scoreboard queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] in1, in2;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [63:0] sb_q[$];

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .in1  (in1),
    .in2  (in2),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses as seen at the falling edge.
  always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: present a request for one rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; in1 = a; in2 = b;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
  endtask

  task automatic issue_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
    sb_q.push_back({eh, el});
    issue(o, a, b);
  endtask

  // Wait (bounded) for busy to fall, checking latency, hold and result.
  task automatic wait_result(input string tag, input int already,
                             input logic [31:0] old_hi, input logic [31:0] old_lo);
    int          cyc;
    logic        held;
    logic [63:0] exp;
    cyc  = already;
    held = 1'b1;
    while (busy === 1'b1 && cyc < 100) begin
      if (hi !== old_hi || lo !== old_lo) held = 1'b0;
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd32);
    chk({tag, "_hold"}, {63'd0, held}, 64'd1);
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      exp = sb_q.pop_front();
      chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
      chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
    end
  endtask

  initial begin
    logic [31:0] ph, pl;
    int          dc;
    reset = 1'b1; start = 1'b0; op = OP_NOP; in1 = '0; in2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);

    // MULT -2 x 3, then done is a single pulse
    issue_md(OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    chk("mult_busy_e0", {63'd0, busy}, 64'd1);
    wait_result("mult_m2x3", 0, 32'd0, 32'd0);
    @(negedge clk);
    chk("mult_done_pulse", {63'd0, done}, 64'd0);
    chk("mult_done_count", 64'(done_cnt), 64'd1);

    // MULTU max x max
    ph = hi; pl = lo;
    issue_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_result("multu_max", 0, ph, pl);

    // MULT 0x80000000 x 2 signed = -2^32
    @(negedge clk);
    ph = hi; pl = lo;
    issue_md(OP_MULT, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0000_0000);
    wait_result("mult_minint", 0, ph, pl);

    // DIV -7 / 2, then DIVU 7 / 2 issued on the done cycle
    @(negedge clk);
    ph = hi; pl = lo;
    issue_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_result("div_m7d2", 0, ph, pl);
    ph = hi; pl = lo;
    issue_md(OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    chk("b2b_accept_busy", {63'd0, busy}, 64'd1);
    wait_result("divu_7d2", 0, ph, pl);

    // DIV 5 / 0
    @(negedge clk);
    ph = hi; pl = lo;
    issue_md(OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    wait_result("div_by0", 0, ph, pl);

    // DIV 0x80000000 / -1
    @(negedge clk);
    ph = hi; pl = lo;
    issue_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    wait_result("div_ovf", 0, ph, pl);

    // MULT 7 x -6 with an MTHI issued at cycle 5 of the run (ignored)
    @(negedge clk);
    ph = hi; pl = lo;
    issue_md(OP_MULT, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
    repeat (4) @(negedge clk);
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    wait_result("mult_mthi_ign", 5, ph, pl);

    // MTLO while idle
    @(negedge clk);
    ph = hi; dc = done_cnt;
    issue(OP_MTLO, 32'hCAFE_F00D, 32'd0);
    chk("mtlo_lo", {32'd0, lo}, {32'd0, 32'hCAFE_F00D});
    chk("mtlo_hi", {32'd0, hi}, {32'd0, ph});
    chk("mtlo_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("mtlo_no_done", 64'(done_cnt), 64'(dc));

    // Reserved op acts as NOP
    issue(OP_RSVD, 32'h1111_1111, 32'd1);
    chk("rsvd_busy", {63'd0, busy}, 64'd0);
    chk("rsvd_hilo", {hi, lo}, {ph, 32'hCAFE_F00D});

    // Reset at cycle 10 of a DIVU: abort, no done
    dc = done_cnt;
    issue(OP_DIVU, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    repeat (40) @(negedge clk);
    chk("rst_mid_no_done", 64'(done_cnt), 64'(dc));
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_hilo.md
# muldiv_hilo

Multi-cycle multiply/divide unit that owns the HI/LO architectural registers. It sits beside the single-cycle ALU and replaces its combinational mult/div path with an iterative engine. It is the consumer end of the ALU's {HI, LO} result convention: the CPU issues an operation, stalls on `busy`, then reads HI/LO for mfhi/mflo. It also serves mthi/mtlo writes.

## Interface
- `WIDTH`, 32, operand and register width. Only 32 is required to work.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: issue request, sampled each rising edge.
- `op` input 3: operation code from the shared package.
- `in1` input WIDTH: rs operand or dividend; also the mthi/mtlo source.
- `in2` input WIDTH: rt operand or divisor.
- `busy` output 1: an operation is in progress, and the CPU must stall on it.
- `done` output 1: one-cycle pulse on the cycle after a mult/div result lands in HI/LO.
- `hi` output WIDTH: current HI register.
- `lo` output WIDTH: current LO register.

## Operation
- Op codes:
  - NOP = 000
  - MULT = 001
  - MULTU = 010
  - DIV = 011
  - DIVU = 100
  - MTHI = 101
  - MTLO = 110
  - 111 is reserved and treated as NOP.
- Accept condition: `start && !busy && op != NOP`.
- A start while `busy` = 1 is ignored entirely. There is no queue.
- MTHI/MTLO complete at the accept edge:
  - HI (or LO) takes `in1`.
  - The other register is unchanged.
  - `busy` and `done` stay 0.
- Mult/div accept edge:
  - Latch the magnitudes of the operands. Signed ops take two's-complement absolute values; unsigned ops use the raw values.
  - Latch the result sign flags.
  - Clear the iteration counter and set `busy`.
- States:
  - IDLE: moves to RUN on a mult/div accept.
  - RUN: moves to IDLE on the edge where the 32nd iteration completes.
- MULT/MULTU datapath:
  - Unsigned shift-add, one multiplier bit per cycle, 64-bit accumulator.
  - Signed: negate the 64-bit product if the operand signs differ.
  - Result: HI = product[63:32], LO = product[31:0].
- DIV/DIVU datapath:
  - Restoring division, one quotient bit per cycle.
  - Result: LO = quotient, HI = remainder.
  - Signed quotient sign = sign(in1) XOR sign(in2).
  - Signed remainder sign = sign(in1), i.e. truncation toward zero.
- Sign fix-up is applied combinationally in the final iteration. There is no extra cycle.
- Special cases:
  - Divide by zero (any signedness): HI = in1, LO = 0xFFFFFFFF. It still takes full latency.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `hi`/`lo` hold their old values throughout RUN and update only at completion.

## Timing
- Reset values:
  - `busy` = 0, `done` = 0.
  - `hi` = 0, `lo` = 0.
  - State = IDLE.
- Mult/div timeline, with the accept at edge E0:
  - `busy` = 1 from after E0 until after E32.
  - HI/LO are written at E32.
  - `busy` = 0 after E32.
  - `done` = 1 for the single cycle between E32 and E33.
- Latency: 32 cycles from accept to HI/LO valid. Throughput is one op per 33 cycles when starts are back-to-back.
- A new start is accepted on the very edge where `done` is high, since `busy` is already 0 then.
- MTHI/MTLO: the value is visible on `hi`/`lo` one cycle after the accept edge. An MTHI/MTLO issued during RUN is ignored.
- Reset mid-operation: at the next edge the unit aborts, all state returns to reset values, and no `done` pulse is produced.

## Structure
- Shared package `muldiv_pkg` holds:
  - the op-code localparams;
  - a `WIDTH` default constant;
  - the state encoding: IDLE = 1'b0, RUN = 1'b1.
- Sub-module `muldiv_core`:
  - Contents: iteration counter, accumulator, shift registers and sign fix-up.
  - Interface: `clk`/`reset`/start/op/operands in; busy/result_hi/result_lo/result_valid out.
- Top-level `muldiv_hilo` holds:
  - the HI/LO registers;
  - the accept logic;
  - the mthi/mtlo path;
  - `done` generation.

## Test plan
- MULT -2 × 3:
  - Stimulus: `in1` = 0xFFFFFFFE, `in2` = 3.
  - Response: `busy` high for 32 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA, and `done` pulses once.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: HI = 0xFFFFFFFE, LO = 0x00000001.
- Signed and unsigned divide:
  - DIV -7 / 2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU 7 / 2: LO = 3, HI = 1.
  - Back-to-back: the second start is issued on the `done` cycle and is accepted.
- Divide corner cases:
  - DIV 5 / 0: HI = 5, LO = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Ignored and immediate requests:
  - MTHI 0x12345678 issued at cycle 5 of a MULT: ignored; the MULT result is correct.
  - MTLO 0xCAFEF00D issued while idle: `lo` = 0xCAFEF00D next cycle; `hi` unchanged; no `done`.
- `reset` asserted at cycle 10 of a DIVU: the next cycle has `busy` = 0, `hi` = `lo` = 0, and `done` never asserts.
